frame_seq_ctrl: RTL and testbench
=================================

FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

Interface
REQ-001 Parameter H_DISP, default 640, active pixels per line.
REQ-002 Parameter V_DISP, default 480, active lines per frame.
REQ-003 clk  input  1  pixel clock, 25 MHz; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse; arms a capture run.
REQ-006 stop  input  1  one-cycle pulse; ends the run after the current frame.
REQ-007 frame_num  input  8  frames per run; 0 = continuous until stop; sampled on start.
REQ-008 in_vsync  input  1  source field sync, low during sync.
REQ-009 in_de  input  1  source data enable, high per active pixel.
REQ-010 proc_en  output  1  gate for the edge datapath; high when in_de belongs to a captured frame.
REQ-011 pix_x  output  10  column of the pixel qualified by proc_en.
REQ-012 pix_y  output  10  row of the pixel qualified by proc_en.
REQ-013 border  output  1  high with proc_en when pix_x==0, pix_x==H_DISP-1, pix_y==0 or pix_y==V_DISP-1 (3x3 kernel mask).
REQ-014 sof / eof  output  1 each  one-cycle pulses with first / last pixel of a captured frame.
REQ-015 busy  output  1  high from accepted start until done.
REQ-016 done  output  1  one-cycle pulse at end of run.
REQ-017 frame_cnt  output  8  frames completed in current run.
REQ-018 err  output  1  sticky framing error; cleared by start.

Function
REQ-019 FSM states: IDLE, WAIT_VS, ACTIVE, FINISH.
REQ-020 IDLE: start -> WAIT_VS, busy=1, frame_cnt=0, err=0, frame_num latched; stop ignored.
REQ-021 WAIT_VS: on in_vsync falling edge (1->0) -> ACTIVE with pix counters zeroed; in_de ignored until then (partial frame never captured).
REQ-022 ACTIVE: each in_de cycle -> proc_en=1 next cycle with pix_x/pix_y of that pixel; all outputs registered, latency exactly 1 cycle from in_de.
REQ-023 pix_x increments per pixel and wraps H_DISP-1 -> 0 with pix_y+1; pix_y wraps to 0 only via frame end.
REQ-024 sof asserted with pixel (0,0); eof with pixel (H_DISP-1,V_DISP-1); frame_cnt increments in the eof cycle, saturating at 255.
REQ-025 After eof: if (frame_num!=0 and frame_cnt+1==frame_num) or stop pending -> FINISH; else stay ACTIVE, counters rezeroed on next in_vsync falling edge; in_de between eof and that edge ignored.
REQ-026 stop in WAIT_VS -> FINISH directly; stop in ACTIVE latched, current frame completes; stop coincident with eof -> FINISH after that frame.
REQ-027 FINISH: done=1 for one cycle, busy=0, -> IDLE; start in FINISH ignored.
REQ-028 start while busy ignored.
REQ-029 err set when in_vsync falls in ACTIVE before eof (short frame) or in_de occurs after eof before next vsync fall (overlong frame); short frame restarts counters and is not counted.
REQ-030 Edge detection of in_vsync uses one registered copy; no input synchronisers (source is same-clock).

Reset
REQ-031 rst_n low: state=IDLE, proc_en=0, pix_x=0, pix_y=0, border=0, sof=0, eof=0, busy=0, done=0, frame_cnt=0, err=0, stop latch=0, vsync delay register=1.
REQ-032 Reset mid-frame aborts run without done pulse; first post-reset capture requires fresh start.

Structure
REQ-033 Shared package holds FSM state encoding and default H_DISP/V_DISP constants, shared with the gray generator and edge datapath.
REQ-034 One sub-module, pix_pos_cnt: x/y counter with wrap, border and sof/eof decode; FSM stays in top.

Verification (H_DISP=8, V_DISP=4 for speed, generator timing scaled accordingly)
REQ-035 start with frame_num=2 mid-frame -> first sof at next vsync fall, 32 proc_en per frame, frame_cnt 1 then 2, done one cycle after 2nd eof, busy low.
REQ-036 frame_num=0, stop during frame 3 -> frame 3 completes, frame_cnt=3, done, no proc_en after.
REQ-037 Border check -> border high on exactly 20 of 32 pixels per frame at the listed coordinates.
REQ-038 Inject vsync fall after 20 pixels -> err=1, frame_cnt unchanged, next full frame counted; start clears err.
REQ-039 rst_n low in middle of frame 1 -> all outputs at reset values within same cycle, no done; restart captures normally.
REQ-040 start while busy and stop in IDLE -> no state change, frame_cnt unchanged.

Source files
------------

// File: rtl/frame_seq_ctrl_pkg.sv
// Shared types and constants for the capture sequencer, gray generator and edge datapath.
// Latency: none (declarations only).
// Backpressure: none; the source cannot be stalled.
package frame_seq_ctrl_pkg;

  // Active-video defaults for the 640x480 capture path.
  localparam int H_DISP_DEF = 640;
  localparam int V_DISP_DEF = 480;

  // Pixel coordinate width and frame counter width.
  localparam int POS_W = 10;
  localparam int CNT_W = 8;

  // Capture run sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_FINISH  = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/frame_seq_ctrl_pos.sv
// pix_pos_cnt: raster x/y position counter with registered border, sof and eof decode.
// Latency: 1 cycle from adv to proc_en and the coordinate/flag outputs.
// Backpressure: none; every adv pulse is a pixel that must be consumed.
module pix_pos_cnt
  import frame_seq_ctrl_pkg::*;
#(
  parameter int H_DISP = H_DISP_DEF,
  parameter int V_DISP = V_DISP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic             last,
  output logic             proc_en,
  output logic [POS_W-1:0] pix_x,
  output logic [POS_W-1:0] pix_y,
  output logic             border,
  output logic             sof,
  output logic             eof
);

  localparam logic [POS_W-1:0] X_LAST = POS_W'(H_DISP - 1);
  localparam logic [POS_W-1:0] Y_LAST = POS_W'(V_DISP - 1);

  logic [POS_W-1:0] cnt_x;
  logic [POS_W-1:0] cnt_y;
  logic             x_last;
  logic             y_last;
  logic             x_first;
  logic             y_first;

  assign x_last  = (cnt_x == X_LAST);
  assign y_last  = (cnt_y == Y_LAST);
  assign x_first = (cnt_x == '0);
  assign y_first = (cnt_y == '0);
  assign last    = x_last && y_last;

  // Position of the next pixel: wraps per line, and back to (0,0) after the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (clr) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (adv) begin
      if (last) begin
        cnt_x <= '0;
        cnt_y <= '0;
      end else if (x_last) begin
        cnt_x <= '0;
        cnt_y <= cnt_y + 1'b1;
      end else begin
        cnt_x <= cnt_x + 1'b1;
      end
    end
  end

  // Registered pixel qualifier, coordinates and kernel-mask / frame-boundary flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_en <= 1'b0;
      pix_x   <= '0;
      pix_y   <= '0;
      border  <= 1'b0;
      sof     <= 1'b0;
      eof     <= 1'b0;
    end else begin
      proc_en <= adv;
      border  <= adv && (x_first || x_last || y_first || y_last);
      sof     <= adv && x_first && y_first;
      eof     <= adv && last;
      if (adv) begin
        pix_x <= cnt_x;
        pix_y <= cnt_y;
      end
    end
  end

endmodule

// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl: arms on start, captures whole frames aligned to the vsync fall, stops on count or stop.
// Latency: pixel outputs exactly 1 cycle after in_de; done 1 cycle after the final eof.
// Backpressure: none; source is free-running, pixels outside a captured frame are dropped.
module frame_seq_ctrl
  import frame_seq_ctrl_pkg::*;
#(
  parameter int H_DISP = H_DISP_DEF,
  parameter int V_DISP = V_DISP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] frame_num,
  input  logic             in_vsync,
  input  logic             in_de,
  output logic             proc_en,
  output logic [POS_W-1:0] pix_x,
  output logic [POS_W-1:0] pix_y,
  output logic             border,
  output logic             sof,
  output logic             eof,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err
);

  fsm_state_t       state;
  logic             vs_q;
  logic             vs_fall;
  logic             in_frame;
  logic             stop_pend;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic             run_end;
  logic             pos_adv;
  logic             pos_clr;
  logic             pos_last;

  // Source shares our clock, so one delayed copy is enough to find the sync edge.
  assign vs_fall  = vs_q && !in_vsync;
  // in_frame is cleared at eof: pixels until the next sync fall are overlong, not captured.
  assign pos_adv  = (state == ST_ACTIVE) && in_frame && in_de && !vs_fall;
  assign pos_clr  = vs_fall && ((state == ST_WAIT_VS) || (state == ST_ACTIVE));
  assign cnt_inc  = frame_cnt + 1'b1;
  assign cnt_next = (frame_cnt == '1) ? frame_cnt : cnt_inc;
  // A coincident stop pulse counts as pending so it ends the run at this eof.
  assign run_end  = ((num_q != '0) && (cnt_inc == num_q)) || stop_pend || stop;

  pix_pos_cnt #(
    .H_DISP (H_DISP),
    .V_DISP (V_DISP)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pos_clr),
    .adv     (pos_adv),
    .last    (pos_last),
    .proc_en (proc_en),
    .pix_x   (pix_x),
    .pix_y   (pix_y),
    .border  (border),
    .sof     (sof),
    .eof     (eof)
  );

  // Previous in_vsync level; idles high so a reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= in_vsync;
    end
  end

  // Run sequencer with registered busy/done/frame_cnt/err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      err       <= 1'b0;
      stop_pend <= 1'b0;
      in_frame  <= 1'b0;
      num_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WAIT_VS;
            busy      <= 1'b1;
            frame_cnt <= '0;
            err       <= 1'b0;
            stop_pend <= 1'b0;
            in_frame  <= 1'b0;
            num_q     <= frame_num;
          end
        end
        ST_WAIT_VS: begin
          if (stop) begin
            state <= ST_FINISH;
          end else if (vs_fall) begin
            state    <= ST_ACTIVE;
            in_frame <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (vs_fall) begin
            // Sync before eof means the frame was short; drop it and restart counting.
            if (in_frame) begin
              err <= 1'b1;
            end
            in_frame <= 1'b1;
          end else if (in_de) begin
            if (!in_frame) begin
              err <= 1'b1;
            end else if (pos_last) begin
              frame_cnt <= cnt_next;
              in_frame  <= 1'b0;
              if (run_end) begin
                state <= ST_FINISH;
              end
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
module tb_frame_seq_ctrl;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int NPIX = H * V;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] frame_num = 8'd0;
  logic       in_vsync = 1'b1;
  logic       in_de = 1'b0;
  logic       proc_en;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       border;
  logic       sof;
  logic       eof;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;
  logic       err;

  always #5 clk = ~clk;

  frame_seq_ctrl #(.H_DISP(H), .V_DISP(V)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .frame_num (frame_num),
    .in_vsync  (in_vsync),
    .in_de     (in_de),
    .proc_en   (proc_en),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .border    (border),
    .sof       (sof),
    .eof       (eof),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt),
    .err       (err)
  );

  int tests  = 0;
  int errors = 0;

  typedef struct { int x; int y; bit b; bit s; bit e; } pix_t;
  typedef struct { bit busy; bit err; int cnt; bit done; } stat_t;

  pix_t  pix_q[$];
  stat_t stat_q[$];

  // Reference model: a run is armed, locks onto a sync fall, then numbers pixels linearly.
  bit m_run, m_synced, m_in_frame, m_stop, m_err, m_fin, m_vs_prev;
  int m_idx, m_frames, m_target;
  int bcount = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_synced = 0; m_in_frame = 0; m_stop = 0; m_err = 0; m_fin = 0;
    m_vs_prev = 1; m_idx = 0; m_frames = 0; m_target = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input int fn, input bit vs, input bit de);
    bit    fall;
    bit    done_e;
    pix_t  pe;
    stat_t se;
    fall      = m_vs_prev && !vs;
    done_e    = 0;
    m_vs_prev = vs;
    if (m_fin) begin
      m_fin = 0; m_run = 0; done_e = 1;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1; m_frames = 0; m_err = 0; m_target = fn; m_stop = 0;
        m_synced = 0; m_in_frame = 0;
      end
    end else if (!m_synced) begin
      if (sp) m_fin = 1;
      else if (fall) begin m_synced = 1; m_in_frame = 1; m_idx = 0; end
    end else begin
      if (sp) m_stop = 1;
      if (fall) begin
        if (m_in_frame) m_err = 1;
        m_in_frame = 1; m_idx = 0;
      end else if (de) begin
        if (!m_in_frame) m_err = 1;
        else begin
          pe.x = m_idx % H;
          pe.y = m_idx / H;
          pe.b = (pe.x == 0) || (pe.x == H - 1) || (pe.y == 0) || (pe.y == V - 1);
          pe.s = (m_idx == 0);
          pe.e = (m_idx == NPIX - 1);
          pix_q.push_back(pe);
          if (m_idx == NPIX - 1) begin
            if (m_frames < 255) m_frames++;
            m_in_frame = 0; m_idx = 0;
            if ((m_target != 0 && m_frames == m_target) || m_stop) m_fin = 1;
          end else m_idx++;
        end
      end
    end
    se.busy = m_run; se.err = m_err; se.cnt = m_frames; se.done = done_e;
    stat_q.push_back(se);
  endtask

  // One source cycle: drive inputs after the falling edge and record what the next edge must produce.
  task automatic cyc(input bit st, input bit sp, input int fn, input bit vs, input bit de);
    @(negedge clk);
    start = st; stop = sp; frame_num = 8'(fn); in_vsync = vs; in_de = de;
    model_step(st, sp, fn, vs, de);
  endtask

  task automatic idle(input int n, input int fn);
    for (int i = 0; i < n; i++) cyc(0, 0, fn, 1, 0);
  endtask

  task automatic mid_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_proc_en", int'(proc_en), 0);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_pix_y", int'(pix_y), 0);
    chk("rst_border", int'(border), 0);
    chk("rst_sof_eof", int'({sof, eof}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_err", int'(err), 0);
    pix_q.delete();
    stat_q.delete();
    model_reset();
    start = 0; stop = 0; in_de = 0; in_vsync = 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Sync pulse, back porch, npix active pixels with random bubbles and line blanking.
  task automatic send_frame(input int npix, input int start_at, input int stop_at,
                            input int fn, input int rst_at = -1);
    cyc(0, 0, fn, 0, 0);
    cyc(0, 0, fn, 0, 0);
    idle(2, fn);
    for (int p = 0; p < npix; p++) begin
      if ($urandom_range(0, 3) == 0) cyc(0, 0, fn, 1, 0);
      cyc(p == start_at, p == stop_at, fn, 1, 1);
      if (p == rst_at) begin
        mid_reset();
        return;
      end
      if (p % H == H - 1) idle($urandom_range(1, 3), fn);
    end
    idle(1, fn);
  endtask

  // Monitor: pops expected status every edge and an expected pixel whenever proc_en is seen.
  initial begin
    pix_t  p;
    stat_t s;
    forever begin
      @(posedge clk);
      #2;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        chk("busy", int'(busy), int'(s.busy));
        chk("err", int'(err), int'(s.err));
        chk("frame_cnt", int'(frame_cnt), s.cnt);
        chk("done", int'(done), int'(s.done));
      end
      if (proc_en) begin
        if (pix_q.size() == 0) chk("unexpected_proc_en", 1, 0);
        else begin
          p = pix_q.pop_front();
          chk("pix_x", int'(pix_x), p.x);
          chk("pix_y", int'(pix_y), p.y);
          chk("border", int'(border), int'(p.b));
          chk("sof", int'(sof), int'(p.s));
          chk("eof", int'(eof), int'(p.e));
          if (p.s) bcount = 0;
          if (border) bcount++;
          if (p.e) chk("border_per_frame", bcount, 20);
        end
      end else begin
        chk("flags_without_proc_en", int'({sof, eof, border}), 0);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int fn, npix, sp_at, r;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("init_proc_en", int'(proc_en), 0);
    chk("init_pix_xy", int'({pix_x, pix_y}), 0);
    chk("init_flags", int'({border, sof, eof}), 0);
    chk("init_busy_done", int'({busy, done}), 0);
    chk("init_frame_cnt", int'(frame_cnt), 0);
    chk("init_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // No start: nothing captured; stop while idle has no effect.
    send_frame(NPIX, -1, -1, 0);
    cyc(0, 1, 0, 1, 0);
    idle(3, 0);
    chk("idle_busy", int'(busy), 0);

    // Two-frame run armed mid-frame; a start while busy carries a different count.
    send_frame(NPIX, 10, -1, 2);
    send_frame(NPIX, 5, -1, 7);
    send_frame(NPIX, -1, -1, 2);
    send_frame(NPIX, -1, -1, 2);
    idle(4, 2);
    chk("two_frame_cnt", int'(frame_cnt), 2);
    chk("two_frame_busy", int'(busy), 0);

    // Continuous run stopped during frame 3.
    cyc(1, 0, 0, 1, 0);
    send_frame(NPIX, -1, -1, 0);
    send_frame(NPIX, -1, -1, 0);
    send_frame(NPIX, -1, 15, 0);
    send_frame(NPIX, -1, -1, 0);
    idle(4, 0);
    chk("stop_frame_cnt", int'(frame_cnt), 3);

    // Stop before any sync fall ends the run with nothing captured.
    cyc(1, 0, 0, 1, 0);
    idle(3, 0);
    cyc(0, 1, 0, 1, 0);
    idle(3, 0);
    send_frame(NPIX, -1, -1, 0);
    chk("wait_stop_cnt", int'(frame_cnt), 0);

    // Short frame flags err and is not counted; next start clears err; overlong frame flags err.
    cyc(1, 0, 2, 1, 0);
    send_frame(NPIX, -1, -1, 2);
    send_frame(20, -1, -1, 2);
    send_frame(NPIX, -1, -1, 2);
    idle(3, 2);
    chk("short_err", int'(err), 1);
    chk("short_cnt", int'(frame_cnt), 2);
    cyc(1, 0, 2, 1, 0);
    idle(1, 2);
    chk("start_clears_err", int'(err), 0);
    send_frame(NPIX + 1, -1, -1, 2);
    send_frame(NPIX, -1, -1, 2);
    idle(3, 2);
    chk("long_err", int'(err), 1);

    // Reset in the middle of frame 1; a fresh start is needed afterwards.
    cyc(1, 0, 1, 1, 0);
    send_frame(NPIX, -1, -1, 1, 12);
    send_frame(NPIX, -1, -1, 1);
    chk("post_reset_idle", int'(busy), 0);
    cyc(1, 0, 1, 1, 0);
    send_frame(NPIX, -1, -1, 1);
    idle(3, 1);
    chk("restart_cnt", int'(frame_cnt), 1);

    // Randomized runs: random counts, stop points and malformed frames.
    for (int run = 0; run < 8; run++) begin
      fn = $urandom_range(0, 3);
      cyc(1, 0, fn, 1, 0);
      for (int f = 0; f < 5; f++) begin
        r     = $urandom_range(0, 9);
        npix  = (r < 7) ? NPIX : ((r == 7) ? 20 : NPIX + 1);
        sp_at = (f == 4 || $urandom_range(0, 4) == 0) ? $urandom_range(0, npix - 1) : -1;
        send_frame(npix, -1, sp_at, fn);
      end
      send_frame(NPIX, -1, 0, fn);
      send_frame(NPIX, -1, 0, fn);
      idle(4, fn);
    end

    // Frame counter saturates in a long continuous run.
    cyc(1, 0, 0, 1, 0);
    for (int f = 0; f < 257; f++) send_frame(NPIX, -1, -1, 0);
    send_frame(NPIX, -1, 3, 0);
    idle(4, 0);
    chk("saturated_cnt", int'(frame_cnt), 255);

    idle(3, 0);
    chk("pixels_drained", pix_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
